// File: rtl/color_matrix_mult_v3_pkg.sv
// Shared helpers for the colour-matrix block: index maths, clog2, rounding and identity constants.
package color_matrix_mult_v3_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Bit offset of coefficient (row i, column j) in the flat coefficient bus.
  function automatic int unsigned coe_idx(input int unsigned i, input int unsigned j,
                                          input int unsigned ch, input int unsigned cw);
    return (i * ch + j) * cw;
  endfunction

  function automatic int unsigned off_idx(input int unsigned i, input int unsigned ow);
    return i * ow;
  endfunction

  // Half an LSB of the integer result, giving round-half-up.
  function automatic logic [63:0] round_const(input int unsigned frac);
    return (frac == 0) ? 64'd0 : (64'd1 << (frac - 1));
  endfunction

  function automatic logic [63:0] ident_entry(input int unsigned i, input int unsigned j,
                                              input int unsigned frac);
    return (i == j) ? (64'd1 << frac) : 64'd0;
  endfunction

endpackage

// File: rtl/color_matrix_mult_v3_dot_row.sv
// One output channel: products, registered adder tree, round/offset, saturate.
module cmm_dot_row
  import color_matrix_mult_v3_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned CH_COUNT           = 3,
  parameter int unsigned COE_WIDTH          = 16,
  parameter int unsigned COE_FRACTION_WIDTH = 10,
  parameter int unsigned OFFSET_WIDTH       = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COE_WIDTH*CH_COUNT-1:0]   coe_row_i,
  input  logic [OFFSET_WIDTH-1:0]         off_i,
  input  logic [PIXEL_WIDTH*CH_COUNT-1:0] di_i,
  output logic [PIXEL_WIDTH-1:0]          pix_o,
  output logic                            clip_o
);

  localparam int unsigned A  = clog2(CH_COUNT);
  localparam int unsigned NP = 1 << A;
  localparam int unsigned PW = COE_WIDTH + PIXEL_WIDTH + 1;
  localparam int unsigned SW = PW + A;
  localparam int unsigned OW = OFFSET_WIDTH + COE_FRACTION_WIDTH + 1;
  localparam int unsigned RW = ((SW > OW) ? SW : OW) + 2;
  localparam logic signed [RW-1:0] Round = RW'(round_const(COE_FRACTION_WIDTH));

  logic signed [SW-1:0]    prod  [NP];
  logic signed [SW-1:0]    lvl_q [A+1][NP];
  logic [OFFSET_WIDTH-1:0] off_q [A+1];
  logic signed [RW-1:0]    off_ext;
  logic signed [RW-1:0]    rnd_d, rnd_q;
  logic [PIXEL_WIDTH-1:0]  pix_d, pix_q;
  logic                    clip_d, clip_q;

  always_comb begin
    for (int k = 0; k < NP; k++) prod[k] = '0;
    for (int k = 0; k < CH_COUNT; k++) begin
      prod[k] = SW'($signed(coe_row_i[k*COE_WIDTH +: COE_WIDTH])) *
                SW'($signed({1'b0, di_i[k*PIXEL_WIDTH +: PIXEL_WIDTH]}));
    end
  end

  // Offset travels with the products so a frame-start swap never splits a pixel.
  always_comb begin
    off_ext = RW'($signed(off_q[A]));
    rnd_d   = RW'(lvl_q[A][0]) + Round + (off_ext <<< COE_FRACTION_WIDTH);
  end

  always_comb begin
    pix_d  = rnd_q[COE_FRACTION_WIDTH +: PIXEL_WIDTH];
    clip_d = 1'b0;
    if (rnd_q[RW-1]) begin
      pix_d  = '0;
      clip_d = 1'b1;
    end else if (|rnd_q[RW-2 : COE_FRACTION_WIDTH+PIXEL_WIDTH]) begin
      pix_d  = '1;
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l <= A; l++) begin
        for (int k = 0; k < NP; k++) lvl_q[l][k] <= '0;
        off_q[l] <= '0;
      end
      rnd_q  <= '0;
      pix_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      for (int k = 0; k < NP; k++) lvl_q[0][k] <= prod[k];
      off_q[0] <= off_i;
      for (int l = 0; l < A; l++) begin
        for (int k = 0; k < NP / 2; k++) begin
          lvl_q[l+1][k] <= lvl_q[l][2*k] + lvl_q[l][2*k+1];
        end
        off_q[l+1] <= off_q[l];
      end
      rnd_q  <= rnd_d;
      pix_q  <= pix_d;
      clip_q <= clip_d;
    end
  end

  assign pix_o  = pix_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/color_matrix_mult_v3.sv
// NxN colour-matrix multiplier with frame-synchronous coefficient staging and bypass.
// Optional clip counter enabled by defining COLOR_MATRIX_MULT_CLIP_CNT_EN.
module color_matrix_mult_v3
  import color_matrix_mult_v3_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned CH_COUNT           = 3,
  parameter int unsigned COE_WIDTH          = 16,
  parameter int unsigned COE_FRACTION_WIDTH = 10,
  parameter int unsigned OFFSET_WIDTH       = 10
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     bypass_i,
  input  logic [COE_WIDTH*CH_COUNT*CH_COUNT-1:0]   coe_i,
  input  logic [OFFSET_WIDTH*CH_COUNT-1:0]         off_i,
  input  logic                                     coe_wr_i,
  output logic                                     coe_pending_o,
  input  logic [PIXEL_WIDTH*CH_COUNT-1:0]          di_i,
  input  logic                                     de_i,
  input  logic                                     hs_i,
  input  logic                                     vs_i,
  output logic [PIXEL_WIDTH*CH_COUNT-1:0]          do_o,
  output logic                                     de_o,
  output logic                                     hs_o,
  output logic                                     vs_o
`ifdef COLOR_MATRIX_MULT_CLIP_CNT_EN
  ,
  output logic [31:0]                              clip_cnt_o
`endif
);

  localparam int unsigned LAT = 3 + clog2(CH_COUNT);
  localparam int unsigned CW  = COE_WIDTH * CH_COUNT * CH_COUNT;
  localparam int unsigned OW  = OFFSET_WIDTH * CH_COUNT;
  localparam int unsigned DW  = PIXEL_WIDTH * CH_COUNT;

  function automatic logic [CW-1:0] ident_set();
    logic [CW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      for (int unsigned j = 0; j < CH_COUNT; j++) begin
        v[coe_idx(i, j, CH_COUNT, COE_WIDTH) +: COE_WIDTH] =
          COE_WIDTH'(ident_entry(i, j, COE_FRACTION_WIDTH));
      end
    end
    return v;
  endfunction

  localparam logic [CW-1:0] Ident = ident_set();

  logic [CW-1:0]    act_coe_q, pend_coe_q;
  logic [OW-1:0]    act_off_q, pend_off_q;
  logic             act_byp_q, pend_byp_q;
  logic             coe_pending_q;
  logic             vs_q;
  logic             frame_start;
  logic [LAT-1:0]   de_sr_q, hs_sr_q, vs_sr_q, byp_sr_q;
  logic [DW-1:0]    di_sr_q [LAT];
  logic [DW-1:0]    row_pix;
  logic [CH_COUNT-1:0] row_clip;

  assign frame_start = vs_i & ~vs_q;

  // A write coincident with frame start lands in pending after the old pending moves to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_coe_q     <= Ident;
      pend_coe_q    <= Ident;
      act_off_q     <= '0;
      pend_off_q    <= '0;
      act_byp_q     <= 1'b0;
      pend_byp_q    <= 1'b0;
      coe_pending_q <= 1'b0;
      vs_q          <= 1'b0;
    end else begin
      vs_q <= vs_i;
      if (frame_start) begin
        act_coe_q <= pend_coe_q;
        act_off_q <= pend_off_q;
        act_byp_q <= pend_byp_q;
      end
      if (coe_wr_i) begin
        pend_coe_q <= coe_i;
        pend_off_q <= off_i;
        pend_byp_q <= bypass_i;
      end
      if (coe_wr_i) begin
        coe_pending_q <= 1'b1;
      end else if (frame_start) begin
        coe_pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_sr_q  <= '0;
      hs_sr_q  <= '0;
      vs_sr_q  <= '0;
      byp_sr_q <= '0;
      for (int k = 0; k < LAT; k++) di_sr_q[k] <= '0;
    end else begin
      de_sr_q    <= {de_sr_q[LAT-2:0], de_i};
      hs_sr_q    <= {hs_sr_q[LAT-2:0], hs_i};
      vs_sr_q    <= {vs_sr_q[LAT-2:0], vs_i};
      byp_sr_q   <= {byp_sr_q[LAT-2:0], act_byp_q};
      di_sr_q[0] <= di_i;
      for (int k = 1; k < LAT; k++) di_sr_q[k] <= di_sr_q[k-1];
    end
  end

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_row
    cmm_dot_row #(
      .PIXEL_WIDTH       (PIXEL_WIDTH),
      .CH_COUNT          (CH_COUNT),
      .COE_WIDTH         (COE_WIDTH),
      .COE_FRACTION_WIDTH(COE_FRACTION_WIDTH),
      .OFFSET_WIDTH      (OFFSET_WIDTH)
    ) u_row (
      .clk      (clk),
      .rst      (rst),
      .coe_row_i(act_coe_q[coe_idx(i, 0, CH_COUNT, COE_WIDTH) +: CH_COUNT*COE_WIDTH]),
      .off_i    (act_off_q[off_idx(i, OFFSET_WIDTH) +: OFFSET_WIDTH]),
      .di_i     (di_i),
      .pix_o    (row_pix[i*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .clip_o   (row_clip[i])
    );
  end

  assign do_o          = byp_sr_q[LAT-1] ? di_sr_q[LAT-1] : row_pix;
  assign de_o          = de_sr_q[LAT-1];
  assign hs_o          = hs_sr_q[LAT-1];
  assign vs_o          = vs_sr_q[LAT-1];
  assign coe_pending_o = coe_pending_q;

`ifdef COLOR_MATRIX_MULT_CLIP_CNT_EN
  logic        vs_o_q;
  logic [31:0] cnt_q, clip_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_o_q     <= 1'b0;
      cnt_q      <= '0;
      clip_cnt_q <= '0;
    end else begin
      vs_o_q <= vs_o;
      if (vs_o & ~vs_o_q) begin
        clip_cnt_q <= cnt_q;
        cnt_q      <= '0;
      end else if (de_o && !byp_sr_q[LAT-1] && (|row_clip) && !(&cnt_q)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign clip_cnt_o = clip_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = ^row_clip;
`endif

endmodule

// File: tb/tb_color_matrix_mult_v3.sv
// Directed bench for color_matrix_mult_v3 at default parameters (3 channels, Q6.10 coefficients).
module tb_color_matrix_mult_v3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bypass_i = 1'b0;
  logic [143:0] coe_i = '0;
  logic [29:0]  off_i = '0;
  logic         coe_wr_i = 1'b0;
  logic         coe_pending_o;
  logic [23:0]  di_i = '0;
  logic         de_i = 1'b0;
  logic         hs_i = 1'b0;
  logic         vs_i = 1'b0;
  logic [23:0]  do_o;
  logic         de_o, hs_o, vs_o;
`ifdef COLOR_MATRIX_MULT_CLIP_CNT_EN
  logic [31:0]  clip_cnt_o;
`endif

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  color_matrix_mult_v3 dut (
    .clk          (clk),
    .rst          (rst),
    .bypass_i     (bypass_i),
    .coe_i        (coe_i),
    .off_i        (off_i),
    .coe_wr_i     (coe_wr_i),
    .coe_pending_o(coe_pending_o),
    .di_i         (di_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
`ifdef COLOR_MATRIX_MULT_CLIP_CNT_EN
    ,
    .clip_cnt_o   (clip_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] diag(input logic [15:0] d);
    logic [143:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) v[(i*3+i)*16 +: 16] = d;
    return v;
  endfunction

  function automatic logic [23:0] px(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [29:0] offs(input logic [9:0] o);
    return {o, o, o};
  endfunction

  task automatic load(input logic [143:0] c, input logic [29:0] o, input logic b);
    @(negedge clk);
    coe_i = c; off_i = o; bypass_i = b; coe_wr_i = 1'b1;
    @(negedge clk);
    coe_wr_i = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    vs_i = 1'b1;
    @(negedge clk);
    vs_i = 1'b0;
  endtask

  // One pixel in, expect it exactly 5 edges later and not at edge 4.
  task automatic run_px(input string tag, input logic [23:0] p, input logic [23:0] exp);
    @(negedge clk);
    di_i = p; de_i = 1'b1;
    @(negedge clk);
    di_i = '0; de_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 check({tag, " de_o early"}, 32'(de_o), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " do_o"}, 32'(do_o), 32'(exp));
    check({tag, " de_o"}, 32'(de_o), 32'd1);
  endtask

  logic [143:0] mat;

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset do_o", 32'(do_o), 32'd0);
    check("reset de_o", 32'(de_o), 32'd0);
    check("reset pending", 32'(coe_pending_o), 32'd0);
    rst = 1'b0;

    // Identity after reset
    run_px("ident", px(10, 20, 30), px(10, 20, 30));
    check("ident pending", 32'(coe_pending_o), 32'd0);

    // hs delay
    @(negedge clk); hs_i = 1'b1;
    @(negedge clk); hs_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("hs_o early", 32'(hs_o), 32'd0);
    @(posedge clk);
    #1 check("hs_o", 32'(hs_o), 32'd1);

    // 0.5 diagonal, round half up
    load(diag(16'h0200), '0, 1'b0);
    check("half pending set", 32'(coe_pending_o), 32'd1);
    frame();
    check("half pending clr", 32'(coe_pending_o), 32'd0);
    run_px("half", px(3, 5, 255), px(2, 3, 128));

    // Full matrix: ch0=p0+p1, ch1=0.5*p2, ch2=-p0+2*p2
    mat = '0;
    mat[0*16 +: 16] = 16'h0400;
    mat[1*16 +: 16] = 16'h0400;
    mat[5*16 +: 16] = 16'h0200;
    mat[6*16 +: 16] = 16'hFC00;
    mat[8*16 +: 16] = 16'h0800;
    load(mat, '0, 1'b0);
    frame();
    run_px("matrix", px(10, 20, 30), px(30, 15, 50));

    // Saturation
    load(diag(16'h0800), '0, 1'b0);
    frame();
    run_px("x2 sat", px(200, 200, 200), px(255, 255, 255));
    run_px("x2", px(100, 20, 127), px(200, 40, 254));
    load(diag(16'hFC00), '0, 1'b0);
    frame();
    run_px("neg sat", px(1, 1, 1), px(0, 0, 0));
    load(diag(16'h0400), offs(10'h3EC), 1'b0);
    frame();
    run_px("off -20 sat", px(10, 10, 10), px(0, 0, 0));
    run_px("off -20", px(30, 20, 25), px(10, 0, 5));
    load(diag(16'h0400), offs(10'd100), 1'b0);
    frame();
    run_px("off +100", px(200, 100, 50), px(255, 200, 150));

    // Staging mid-frame
    load(diag(16'h0400), '0, 1'b0);
    frame();
    run_px("stage pre", px(50, 50, 50), px(50, 50, 50));
    load(diag(16'h0800), '0, 1'b0);
    check("stage pending", 32'(coe_pending_o), 32'd1);
    run_px("stage held", px(50, 50, 50), px(50, 50, 50));
    frame();
    check("stage pending clr", 32'(coe_pending_o), 32'd0);
    run_px("stage new", px(50, 50, 50), px(100, 100, 100));

    // Write coincident with frame start
    load(diag(16'h0400), '0, 1'b0);
    @(negedge clk);
    vs_i = 1'b1; coe_i = diag(16'h0200); coe_wr_i = 1'b1;
    @(negedge clk);
    vs_i = 1'b0; coe_wr_i = 1'b0;
    check("coinc pending", 32'(coe_pending_o), 32'd1);
    run_px("coinc old", px(50, 50, 50), px(50, 50, 50));
    frame();
    check("coinc pending clr", 32'(coe_pending_o), 32'd0);
    run_px("coinc new", px(50, 51, 52), px(25, 26, 26));

    // Bypass staged with a non-identity matrix
    load(diag(16'h0800), '0, 1'b1);
    frame();
    run_px("bypass", px(7, 8, 200), px(7, 8, 200));

    // Reset mid-stream
    load(diag(16'h0800), '0, 1'b0);
    frame();
    run_px("pre rst", px(40, 40, 40), px(80, 80, 80));
    load(diag(16'h0400), '0, 1'b0);
    @(negedge clk);
    di_i = px(90, 90, 90); de_i = 1'b1;
    repeat (6) @(negedge clk);
    check("stream do_o", 32'(do_o), 32'(px(180, 180, 180)));
    #2 rst = 1'b1;
    #1;
    check("async rst do_o", 32'(do_o), 32'd0);
    check("async rst de_o", 32'(de_o), 32'd0);
    check("async rst pending", 32'(coe_pending_o), 32'd0);
    @(negedge clk);
    de_i = 1'b0; di_i = '0; rst = 1'b0;
    run_px("post rst ident", px(40, 40, 40), px(40, 40, 40));

`ifdef COLOR_MATRIX_MULT_CLIP_CNT_EN
    load(diag(16'h0800), '0, 1'b0);
    frame();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      di_i = (n < 4) ? px(200, 200, 200) : px(50, 50, 50);
      de_i = 1'b1;
    end
    @(negedge clk);
    de_i = 1'b0; di_i = '0;
    frame();
    repeat (8) @(negedge clk);
    check("clip_cnt", clip_cnt_o, 32'd4);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
